ads8688_spi_responder: RTL
==========================

# ads8688_spi_responder

SPI slave that emulates the ADS8688 ADC's manual-channel command/response protocol. It is the far end of our ADS8688 manual-channel controller and is used in loopback fabrics and FPGA-based board emulation.
- Each 32-bit frame carries a 16-bit command in its first half. The block returns, in the second half, the conversion result produced by the previous frame's channel command.
- Conversion data comes from a local sample source through a req/valid handshake.
- All SPI inputs are oversampled and synchronized into clk; there is no SCLK-domain logic.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer depth on sclk/csn/mosi (≥2).
- FRAME_BITS, 32, SCLK cycles per valid frame (16 command + 16 data).

Ports:
- clk  in  1  system clock, ≥ 8× SCLK frequency with SYNC_STAGES=2.
- arstn  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock from master, CPOL=0, CPHA=1.
- csn  in  1  chip select, active-low.
- mosi  in  1  command data, MSB first.
- miso  out  1  response data, MSB first.
- cmd_valid  out  1  one-clk pulse when a complete frame's command is accepted.
- cmd_word  out  16  last accepted command; held until the next accepted command.
- conv_req  out  1  conversion request; held until conv_valid is seen.
- conv_ch  out  3  channel being requested; stable while conv_req=1.
- conv_data  in  16  conversion result, sampled when conv_req & conv_valid.
- conv_valid  in  1  sample source acknowledge.
- frame_err  out  1  one-clk pulse on a malformed frame.
- ovr_err  out  1  one-clk pulse when a frame starts while conv_req is still pending.

## Operation
- **Synchronizers:** SYNC_STAGES flops per input. On reset they load the idle levels: csn=1, sclk=0, mosi=0. Edges are detected from the last two synchronized stages.
- **SPI mode 1:**
  - mosi is sampled on each synchronized sclk falling edge.
  - On each synchronized sclk rising edge, miso is loaded with tx_sr[31] and tx_sr shifts left by one.
  - miso=0 before the first rising edge of a frame and whenever csn is high.
- **Main FSM, IDLE:** on csn falling edge:
  - load tx_sr={16'h0000, result_reg};
  - clear bit_cnt and rx_sr;
  - go to SHIFT.
- **Main FSM, SHIFT:**
  - Each sclk falling edge: rx_sr={rx_sr[30:0], mosi}; bit_cnt increments, saturating at FRAME_BITS+1.
  - On csn rising edge, return to IDLE:
    - If bit_cnt==FRAME_BITS: cmd_word<=rx_sr[31:16] and pulse cmd_valid. mosi bits [15:0] are ignored.
    - Otherwise: pulse frame_err; cmd_word is unchanged, there is no cmd_valid pulse and no conversion request.
- **Command decode** (on accepted cmd_word):
  - MAN_Ch_n: cmd[15:13]=3'b110, cmd[9:0]=0, n=cmd[12:10] (0xC000, 0xC400 … 0xDC00). Sets conv_ch=n and asserts conv_req in the same cycle as cmd_valid.
  - NO_OP (0x0000): no conversion request; result_reg retains its value.
  - Any other code: reported via cmd_valid/cmd_word only; result_reg is cleared to 0.
- **Conversion FSM:**
  - C_IDLE → C_REQ when a MAN_Ch_n command is accepted.
  - In C_REQ, when conv_valid=1: result_reg<=conv_data, conv_req drops the next cycle, go to C_IDLE.
  - conv_valid is ignored while conv_req=0.
- **Overrun:** if csn falls while in C_REQ:
  - pulse ovr_err and abandon the request (conv_req drops next cycle);
  - result_reg<=0, so that frame's data half is 16'h0000.

## Timing
- **Reset values:** miso=0, cmd_valid=0, cmd_word=16'h0000, conv_req=0, conv_ch=0, frame_err=0, ovr_err=0, result_reg=0. Both FSMs reset to IDLE.
- **Edge latency:** a pin edge is acted on SYNC_STAGES+1 clk later.
  - miso therefore changes 3 clk after an sclk rising edge at default settings.
  - It must settle before the master samples on the falling edge, which requires half-period ≥ 4 clk.
- **Frame end:** cmd_valid, conv_req assertion and frame_err all occur SYNC_STAGES+1 clk after the csn rising edge.
- **Minimum csn-high time:** SYNC_STAGES+2 clk.
- **Conversion deadline:** the result must be handshaken before the next csn falling edge, or ovr_err fires.
- **Simultaneous events:** if conv_valid arrives in the same cycle the csn falling edge is detected, the handshake wins. result_reg is updated and tx_sr loads the new value; no ovr_err.
- **Reset mid-frame:** the frame is lost. If csn is low at reset release, the remainder is treated as a new frame, which ends in frame_err.

## Test plan
- **Command, then readback:** frame 1 mosi=0xC800_0000 with conv_data=0x1234 acked 2 clk after conv_req → cmd_valid, cmd_word=0xC800, conv_ch=2. Frame 2 mosi=0x0000_0000 → miso stream 0x0000_1234, and no conv_req.
- **All channels:** MAN_Ch_0…7 back-to-back, each followed by a read frame → conv_ch=0…7 in order. Each read frame returns the matching conv_data.
- **Short/long frames:** a 31-SCLK frame and a 33-SCLK frame → frame_err pulse each, no cmd_valid, cmd_word unchanged.
- **Overrun:** MAN_Ch_5 with conv_valid held low, then a new frame → ovr_err pulse and conv_req drops. That frame's miso=0x0000_0000.
- **Unknown command:** 0x8500 after a valid result → cmd_valid with cmd_word=0x8500, no conv_req. The next frame returns data 0x0000.
- **Reset:** arstn low mid-frame at bit 10 → all outputs at reset values, then frame_err on the trailing csn rise. A following full frame works normally.

Source files
------------

// File: rtl/ads8688_spi_responder.sv
// ads8688_spi_responder
// SPI mode-1 slave emulating the ADS8688 manual-channel command/response
// protocol. All SPI pins are oversampled in the clk domain. Each frame
// shifts in a command and returns the previous conversion result.
//
// Ports:
//   clk, arstn          system clock, async active-low reset
//   sclk, csn, mosi     SPI pins from master (CPOL=0, CPHA=1)
//   miso                SPI response bit, MSB first
//   cmd_valid           1-clk pulse when a complete frame's command is accepted
//   cmd_word            last accepted command, held
//   conv_req, conv_ch   conversion request and its channel, held until acked
//   conv_data,
//   conv_valid          sample source response, taken when conv_req & conv_valid
//   frame_err           1-clk pulse on a frame with wrong SCLK count
//   ovr_err             1-clk pulse when a frame starts with a request pending
module ads8688_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FRAME_BITS  = 32
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        sclk,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        conv_req,
  output logic [2:0]  conv_ch,
  input  logic [15:0] conv_data,
  input  logic        conv_valid,
  output logic        frame_err,
  output logic        ovr_err
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam int unsigned CMD_W = 16;

  typedef enum logic {M_IDLE, M_SHIFT} main_state_t;
  typedef enum logic {C_IDLE, C_REQ}   conv_state_t;

  main_state_t            m_state;
  conv_state_t            c_state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csn_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   csn_d;
  logic [FRAME_BITS-1:0]  tx_sr;
  logic [FRAME_BITS-1:0]  rx_sr;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CMD_W-1:0]       result_reg;

  logic             sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_bit;
  logic             handshake;
  logic [CMD_W-1:0] rx_cmd;
  logic             is_man;

  // Pin synchronizers plus one delayed copy for edge detection; reset to idle levels
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      sclk_sync <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      csn_d     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      csn_d     <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
  assign csn_rise  = csn_sync[SYNC_STAGES-1] & ~csn_d;
  assign csn_fall  = ~csn_sync[SYNC_STAGES-1] & csn_d;
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  assign handshake = (c_state == C_REQ) && conv_valid;
  assign rx_cmd    = rx_sr[FRAME_BITS-1 -: CMD_W];
  assign is_man    = (rx_cmd[15:13] == 3'b110) && (rx_cmd[9:0] == 10'd0);

  // Frame FSM and conversion FSM with all registered outputs
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      m_state    <= M_IDLE;
      c_state    <= C_IDLE;
      miso       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_word   <= '0;
      conv_req   <= 1'b0;
      conv_ch    <= '0;
      frame_err  <= 1'b0;
      ovr_err    <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      result_reg <= '0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      ovr_err   <= 1'b0;

      if (handshake) begin
        result_reg <= conv_data;
        conv_req   <= 1'b0;
        c_state    <= C_IDLE;
      end

      case (m_state)
        M_IDLE: begin
          miso <= 1'b0;
          if (csn_fall) begin
            // A handshake in the same cycle wins over the overrun
            if (handshake) begin
              tx_sr <= FRAME_BITS'(conv_data);
            end else if (c_state == C_REQ) begin
              tx_sr      <= '0;
              ovr_err    <= 1'b1;
              conv_req   <= 1'b0;
              c_state    <= C_IDLE;
              result_reg <= '0;
            end else begin
              tx_sr <= FRAME_BITS'(result_reg);
            end
            bit_cnt <= '0;
            rx_sr   <= '0;
            m_state <= M_SHIFT;
          end
        end

        M_SHIFT: begin
          if (csn_rise) begin
            m_state <= M_IDLE;
            miso    <= 1'b0;
            if (bit_cnt == CNT_W'(FRAME_BITS)) begin
              cmd_word  <= rx_cmd;
              cmd_valid <= 1'b1;
              if (is_man) begin
                conv_ch  <= rx_cmd[12:10];
                conv_req <= 1'b1;
                c_state  <= C_REQ;
              end else if (rx_cmd != '0) begin
                result_reg <= '0;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              miso  <= tx_sr[FRAME_BITS-1];
              tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
            end
            if (sclk_fall) begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_bit};
              // Saturate one past a full frame so long frames stay detectable
              if (bit_cnt != CNT_W'(FRAME_BITS + 1)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

endmodule
